// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction word encoder: turns field-level requests or LFSR-generated fields into legal
// 32-bit instruction words (illegal requests become a flagged NOP) behind a small valid/ready FIFO.
`timescale 1ns/1ps
module rv32i_inst_encoder #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          ALIGN4     = 1'b1,
    parameter logic [31:0] SEED       = 32'h1ACE_B00C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [9:0]  in_funct,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        gen_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [31:0] emitted_cnt
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    localparam logic [3:0] C_LUI    = 4'd0;
    localparam logic [3:0] C_AUIPC  = 4'd1;
    localparam logic [3:0] C_JAL    = 4'd2;
    localparam logic [3:0] C_JALR   = 4'd3;
    localparam logic [3:0] C_BRANCH = 4'd4;
    localparam logic [3:0] C_LOAD   = 4'd5;
    localparam logic [3:0] C_STORE  = 4'd6;
    localparam logic [3:0] C_OPIMM  = 4'd7;
    localparam logic [3:0] C_OP     = 4'd8;
    localparam logic [3:0] C_FENCE  = 4'd9;
    localparam logic [3:0] C_SYSTEM = 4'd10;

    // Returns {err, word}; an illegal field combination yields {1, NOP}.
    function automatic logic [32:0] encode_word(
        input logic [3:0]  cls,
        input logic [9:0]  funct,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] bj;
        logic [31:0] word;
        logic        legal;
        f3    = funct[2:0];
        f7    = funct[9:3];
        bj    = ALIGN4 ? (imm & 32'hFFFF_FFFD) : imm;
        legal = 1'b1;
        word  = NOP_INST;
        case (cls)
            C_LUI:    word = {imm[31:12], rd, 7'h37};
            C_AUIPC:  word = {imm[31:12], rd, 7'h17};
            C_JAL:    word = {bj[20], bj[10:1], bj[11], bj[19:12], rd, 7'h6F};
            C_JALR: begin
                legal = (f3 == 3'd0);
                word  = {imm[11:0], rs1, 3'd0, rd, 7'h67};
            end
            C_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                word  = {bj[12], bj[10:5], rs2, rs1, f3, bj[4:1], bj[11], 7'h63};
            end
            C_LOAD: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                word  = {imm[11:0], rs1, f3, rd, 7'h03};
            end
            C_STORE: begin
                legal = (f3 <= 3'd2);
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            end
            C_OPIMM: begin
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00);
                    word  = {f7, imm[4:0], rs1, f3, rd, 7'h13};
                end else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    word  = {f7, imm[4:0], rs1, f3, rd, 7'h13};
                end else begin
                    word  = {imm[11:0], rs1, f3, rd, 7'h13};
                end
            end
            C_OP: begin
                legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                word  = {f7, rs2, rs1, f3, rd, 7'h33};
            end
            C_FENCE: begin
                legal = (f3 == 3'd0);
                word  = {imm[11:0], rs1, f3, rd, 7'h0F};
            end
            // rd, rs1 and funct3 are zero; imm[0] selects ECALL or EBREAK
            C_SYSTEM: word = {11'd0, imm[0], 13'd0, 7'h73};
            default:  legal = 1'b0;
        endcase
        return legal ? {1'b0, word} : {1'b1, NOP_INST};
    endfunction

    // Maps LFSR state onto request fields and nudges funct to the nearest legal value.
    function automatic logic [32:0] generate_word(input logic [31:0] state);
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        cls = (state[3:0] > 4'd10) ? C_OPIMM : state[3:0];
        f3  = state[21:19];
        f7  = {1'b0, state[22], 5'd0};
        imm = {{4{state[31]}}, state[31:4]};
        case (cls)
            C_JALR, C_FENCE: f3 = 3'd0;
            C_BRANCH: begin
                if ((f3 == 3'd2) || (f3 == 3'd3)) f3 = 3'd0;
                else                               f3 = f3;
            end
            C_LOAD: begin
                if (f3 == 3'd3)      f3 = 3'd2;
                else if (f3 >= 3'd6) f3 = 3'd5;
                else                 f3 = f3;
            end
            C_STORE: begin
                if (f3 > 3'd2) f3 = 3'd2;
                else           f3 = f3;
            end
            C_OPIMM: begin
                if (f3 != 3'd5) f7 = 7'h00;
                else            f7 = f7;
            end
            C_OP: begin
                if ((f3 != 3'd0) && (f3 != 3'd5)) f7 = 7'h00;
                else                              f7 = f7;
            end
            default: f3 = f3;
        endcase
        return encode_word(cls, {f7, f3}, state[8:4], state[13:9], state[18:14], imm);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [32:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [31:0]      emitted;
    logic             full;
    logic             push;
    logic             pop;
    logic             gen_push;
    logic [32:0]      req_word;
    logic [32:0]      gen_word;
    logic [32:0]      push_word;

    // Encode both candidate sources every cycle.
    always_comb begin
        req_word = encode_word(in_class, in_funct, in_rd, in_rs1, in_rs2, in_imm);
        gen_word = generate_word(lfsr);
    end

    // Galois LFSR step (right shift, feedback from bit 0).
    always_comb begin
        if (lfsr[0]) lfsr_next = {1'b0, lfsr[31:1]} ^ LFSR_TAPS;
        else         lfsr_next = {1'b0, lfsr[31:1]};
    end

    // Handshake flags and source arbitration; a request always wins over the generator.
    always_comb begin
        full      = (count == CNT_W'(FIFO_DEPTH));
        in_ready  = !full;
        out_valid = (count != {CNT_W{1'b0}});
        pop       = out_valid && out_ready;
        push      = 1'b0;
        gen_push  = 1'b0;
        push_word = req_word;
        if (in_valid) begin
            push      = !full;
            push_word = req_word;
        end else if (gen_en) begin
            push      = !full;
            gen_push  = !full;
            push_word = gen_word;
        end else begin
            push      = 1'b0;
        end
    end

    // Pointers, occupancy, LFSR and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= {PTR_W{1'b0}};
            rd_ptr  <= {PTR_W{1'b0}};
            count   <= {CNT_W{1'b0}};
            lfsr    <= SEED;
            emitted <= 32'd0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (gen_push) lfsr <= lfsr_next;
            if (pop)      emitted <= emitted + 32'd1;
        end
    end

    // Storage is not reset; the outputs are gated by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem[wr_ptr] <= push_word;
    end

    // Present the head entry, zero when empty.
    always_comb begin
        if (out_valid) {out_err, out_inst} = fifo_mem[rd_ptr];
        else           {out_err, out_inst} = 33'd0;
    end

    assign emitted_cnt = emitted;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder: arithmetic reference encoder, independent word validity
// check, LFSR generator model, directed known-answer words and randomized traffic.
`timescale 1ns/1ps
module tb_rv32i_inst_encoder;

    localparam int          DEPTH  = 2;
    localparam bit          ALIGN4 = 1'b1;
    localparam logic [31:0] SEED   = 32'h1ACE_B00C;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_class = 4'd0;
    logic [9:0]  in_funct = 10'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        gen_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] emitted_cnt;

    rv32i_inst_encoder #(.FIFO_DEPTH(DEPTH), .ALIGN4(ALIGN4), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .gen_en(gen_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err), .emitted_cnt(emitted_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
        logic        gen;
    } exp_t;

    exp_t        sb_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          m_count = 0;
    logic [31:0] m_lfsr = SEED;
    logic [31:0] m_emit = 32'd0;
    int          load_map[8]   = '{0, 1, 2, 2, 4, 5, 5, 5};
    int          branch_map[8] = '{0, 1, 0, 0, 4, 5, 6, 7};
    int          store_map[8]  = '{0, 1, 2, 2, 2, 2, 2, 2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoder built from shifts and masks on whole 32-bit values.
    function automatic void ref_encode(input logic [31:0] c, input logic [31:0] f3, input logic [31:0] f7,
                                       input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, output logic err, output logic [31:0] inst);
        logic [31:0] bj;
        logic [7:0]  f3_ok;
        logic        ok;
        bj = imm & ~32'h1;
        if (ALIGN4) bj = bj & ~32'h2;
        case (c)
            3, 9:    f3_ok = 8'h01;
            4:       f3_ok = 8'hF3;
            5:       f3_ok = 8'h37;
            6:       f3_ok = 8'h07;
            default: f3_ok = 8'hFF;
        endcase
        ok = f3_ok[f3[2:0]] && (c <= 10);
        if (c == 7 && f3 == 1) ok = (f7 == 0);
        if (c == 7 && f3 == 5) ok = (f7 == 0) || (f7 == 32);
        if (c == 8) ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        case (c)
            0:  inst = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
            1:  inst = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h17;
            2:  inst = 32'h6F | (rd << 7) | (bj & 32'h000F_F000) | (((bj >> 11) & 1) << 20)
                       | (((bj >> 1) & 32'h3FF) << 21) | (((bj >> 20) & 1) << 31);
            3:  inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            4:  inst = (((bj >> 12) & 1) << 31) | (((bj >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                       | (f3 << 12) | (((bj >> 1) & 32'hF) << 8) | (((bj >> 11) & 1) << 7) | 32'h63;
            5:  inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            6:  inst = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                       | ((imm & 32'h1F) << 7) | 32'h23;
            7:  if (f3 == 1 || f3 == 5)
                    inst = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                else
                    inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            8:  inst = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            9:  inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h0F;
            10: inst = 32'h73 | ((imm & 1) << 20);
            default: inst = 32'h13;
        endcase
        err = !ok;
        if (!ok) inst = 32'h0000_0013;
    endfunction

    // Independent decode-side legality check of a finished word.
    function automatic bit is_valid_inst(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h37, 7'h17: return 1'b1;
            7'h6F: return !(ALIGN4 && w[21]);
            7'h67: return f3 == 3'd0;
            7'h63: return (f3 != 3'd2) && (f3 != 3'd3) && !(ALIGN4 && w[8]);
            7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            7'h23: return f3 <= 3'd2;
            7'h13: return (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'h0F: return f3 == 3'd0;
            7'h73: return (w == 32'h0000_0073) || (w == 32'h0010_0073);
            default: return 1'b0;
        endcase
    endfunction

    // Expected generator output for a given LFSR state.
    function automatic void gen_expect(input logic [31:0] s, output logic err, output logic [31:0] inst);
        logic [31:0] c, f3, f7, imm;
        c   = s & 32'hF;
        if (c > 10) c = 7;
        f3  = (s >> 19) & 32'h7;
        f7  = ((s >> 22) & 32'h1) * 32;
        imm = $signed(s) >>> 4;
        if (c == 3 || c == 9) f3 = 0;
        if (c == 4) f3 = branch_map[f3];
        if (c == 5) f3 = load_map[f3];
        if (c == 6) f3 = store_map[f3];
        if (c == 7 && f3 != 5) f7 = 0;
        if (c == 8 && f3 != 0 && f3 != 5) f7 = 0;
        ref_encode(c, f3, f7, (s >> 4) & 32'h1F, (s >> 9) & 32'h1F, (s >> 14) & 32'h1F, imm, err, inst);
    endfunction

    // Reference model: predicts acceptance, occupancy and counter, and queues expected words.
    always @(negedge clk) begin : model
        exp_t        e;
        logic        er;
        logic [31:0] w;
        int          pushed;
        int          popped;
        if (rst) begin
            sb_q.delete();
            m_count = 0;
            m_lfsr  = SEED;
            m_emit  = 32'd0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, (m_count < DEPTH) ? 32'd1 : 32'd0);
            chk("out_valid", {31'd0, out_valid}, (m_count > 0) ? 32'd1 : 32'd0);
            chk("emitted_cnt", emitted_cnt, m_emit);
            popped = (m_count > 0 && out_ready) ? 1 : 0;
            pushed = 0;
            if (in_valid) begin
                if (m_count < DEPTH) begin
                    ref_encode({28'd0, in_class}, {29'd0, in_funct[2:0]}, {25'd0, in_funct[9:3]},
                               {27'd0, in_rd}, {27'd0, in_rs1}, {27'd0, in_rs2}, in_imm, er, w);
                    e.err = er; e.inst = w; e.gen = 1'b0;
                    sb_q.push_back(e);
                    pushed = 1;
                end
            end else if (gen_en && m_count < DEPTH) begin
                gen_expect(m_lfsr, er, w);
                e.err = er; e.inst = w; e.gen = 1'b1;
                sb_q.push_back(e);
                m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'd0);
                pushed = 1;
            end
            m_count = m_count + pushed - popped;
            if (popped == 1) m_emit = m_emit + 32'd1;
        end
    end

    // Monitor: every output handshake is compared against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pop_empty: got %h with no expected word", out_inst);
            end else begin
                e = sb_q.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                if (e.gen) begin
                    chk("gen_valid", {31'd0, is_valid_inst(out_inst)}, 32'd1);
                    chk("gen_err", {31'd0, out_err}, 32'd0);
                end
            end
        end
    end

    task automatic set_req(input int c, input int f, input int d, input int s1, input int s2, input logic [31:0] im);
        in_class = 4'(c); in_funct = 10'(f); in_rd = 5'(d); in_rs1 = 5'(s1); in_rs2 = 5'(s2); in_imm = im;
    endtask

    task automatic rand_req();
        int f7;
        case ($urandom_range(0, 3))
            0:       f7 = 0;
            1:       f7 = 32;
            default: f7 = $urandom_range(0, 127);
        endcase
        set_req($urandom_range(0, 15), (f7 << 3) | $urandom_range(0, 7), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
    endtask

    // Hold a request until accepted (bounded), then check the head word next cycle.
    task automatic send_check(input string nm, input int c, input int f, input int d, input int s1,
                              input int s2, input logic [31:0] im, input logic [31:0] exp_inst, input logic exp_err);
        int t;
        set_req(c, f, d, s1, s2, im);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin t++; @(negedge clk); end
        if (t >= 50) begin
            compared++; mismatched++;
            $display("FAIL %s_accept: timed out waiting for in_ready", nm);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_inst"}, out_inst, exp_inst);
        chk({nm, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0; gen_en = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (out_valid && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            compared++; mismatched++;
            $display("FAIL %s: output did not drain", nm);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_emitted", emitted_cnt, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        send_check("addi", 7, 0, 1, 2, 0, 32'd5, 32'h0051_0093, 1'b0);
        send_check("xori", 7, 3'b100, 3, 4, 0, 32'hFFF, 32'hFFF2_4193, 1'b0);
        send_check("blt", 4, 3'b100, 0, 1, 2, 32'h12, 32'h0020_C863, 1'b0);
        send_check("op_bad", 8, (7'h20 << 3) | 1, 1, 2, 3, 32'd0, 32'h0000_0013, 1'b1);
        send_check("ecall", 10, 0, 0, 0, 0, 32'd0, 32'h0000_0073, 1'b0);
        send_check("ebreak", 10, 3'b010, 5, 6, 7, 32'd1, 32'h0010_0073, 1'b0);
        send_check("class_bad", 12, 0, 1, 1, 1, 32'd0, 32'h0000_0013, 1'b1);
        send_check("load_bad", 5, 3, 1, 2, 0, 32'd4, 32'h0000_0013, 1'b1);

        // Back-pressure burst from a clean start.
        do_reset();
        out_ready = 1'b0;
        set_req(7, 0, 1, 2, 0, 32'd5); in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(7, 4, 3, 4, 0, 32'hFFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("burst_full_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        set_req(6, 2, 0, 8, 9, 32'h7F0); in_valid = 1'b1; out_ready = 1'b1;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 20) begin t++; @(negedge clk); end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        drain("burst_drain");
        @(negedge clk);
        chk("burst_emitted", emitted_cnt, 32'd3);

        // Reset with words in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_req(0, 0, 7, 0, 0, 32'hABCD_E000); in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(2, 0, 1, 0, 0, 32'h0000_0806);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_emitted", emitted_cnt, 32'd0);

        // Mixed random requests, generator and back-pressure.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            rand_req();
            in_valid  = ($urandom_range(0, 1) == 1);
            gen_en    = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
        end

        // Long generator run with occasional competing requests.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            gen_en    = 1'b1;
            out_ready = 1'b1;
            in_valid  = ((i % 97) == 50);
            if (in_valid) rand_req();
        end

        // Generator under back-pressure.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            gen_en    = 1'b1;
            out_ready = ($urandom_range(0, 2) == 0);
        end

        @(posedge clk); #1;
        gen_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain("final_drain");
        @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
